// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : 4-digit time-multiplexed driver for an MC14495-style
//                hex-to-7-segment decoder, with tear-free frame swaps.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] hex_in,
   input  logic [3:0]  point_in,
   input  logic [3:0]  blank_in,
   input  logic        lz_en,
   output logic        ready,
   output logic [3:0]  hex_digit,
   output logic        le,
   output logic        dp,
   output logic [3:0]  anode_n,
   output logic [1:0]  digit_idx
);

   localparam int                   c_PRESC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_PRESC_W-1:0] c_TICK_VAL = c_PRESC_W'(SCAN_DIV - 1);

   logic [c_PRESC_W-1:0] r_presc;
   logic [1:0]           r_idx;
   logic                 r_pending;
   logic [15:0]          r_sh_hex;
   logic [3:0]           r_sh_point;
   logic [3:0]           r_sh_blank;
   logic                 r_sh_lz;
   logic [15:0]          r_act_hex;
   logic [3:0]           r_act_point;
   logic [3:0]           r_act_blank;
   logic                 r_act_lz;

   logic                 w_tick;
   logic                 w_wrap;
   logic [3:0]           w_nib_zero;
   logic [3:0]           w_zero_from;
   logic                 w_lz_sup;
   logic                 w_le;

   assign w_tick = (r_presc == c_TICK_VAL);
   assign w_wrap = w_tick && (r_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc     <= '0;
         r_idx       <= 2'd0;
         r_pending   <= 1'b0;
         r_sh_hex    <= 16'h0000;
         r_sh_point  <= 4'h0;
         r_sh_blank  <= 4'h0;
         r_sh_lz     <= 1'b0;
         r_act_hex   <= 16'h0000;
         r_act_point <= 4'h0;
         r_act_blank <= 4'hF;
         r_act_lz    <= 1'b0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) begin
            r_idx <= r_idx + 2'd1;
         end
         // Swap and capture need opposite pending states, so they never collide.
         if (w_wrap && r_pending) begin
            r_act_hex   <= r_sh_hex;
            r_act_point <= r_sh_point;
            r_act_blank <= r_sh_blank;
            r_act_lz    <= r_sh_lz;
            r_pending   <= 1'b0;
         end
         if (load && !r_pending) begin
            r_sh_hex   <= hex_in;
            r_sh_point <= point_in;
            r_sh_blank <= blank_in;
            r_sh_lz    <= lz_en;
            r_pending  <= 1'b1;
         end
      end
   end

   generate
      for (genvar j = 0; j < 4; j++) begin : g_nib_zero
         assign w_nib_zero[j] = (r_act_hex[4*j +: 4] == 4'h0);
      end
   endgenerate

   // w_zero_from[i]: every nibble from i up to the most significant is zero.
   assign w_zero_from = {w_nib_zero[3],
                         &w_nib_zero[3:2],
                         &w_nib_zero[3:1],
                         &w_nib_zero[3:0]};

   assign w_lz_sup  = r_act_lz && (r_idx != 2'd0) && w_zero_from[r_idx];
   assign w_le      = r_act_blank[r_idx] | w_lz_sup;

   assign ready     = ~r_pending;
   assign hex_digit = r_act_hex[4*r_idx +: 4];
   assign le        = w_le;
   assign dp        = r_act_point[r_idx] & ~w_le;
   assign anode_n   = ~(4'b0001 << r_idx);
   assign digit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Randomized self-checking bench, SCAN_DIV=4 and SCAN_DIV=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] hex_in;
   logic [3:0]  point_in;
   logic [3:0]  blank_in;
   logic        lz_en;

   logic        ready4, le4, dp4, ready1, le1, dp1;
   logic [3:0]  hex_digit4, anode_n4, hex_digit1, anode_n1;
   logic [1:0]  digit_idx4, digit_idx1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.SCAN_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .load(load), .hex_in(hex_in),
      .point_in(point_in), .blank_in(blank_in), .lz_en(lz_en),
      .ready(ready4), .hex_digit(hex_digit4), .le(le4), .dp(dp4),
      .anode_n(anode_n4), .digit_idx(digit_idx4)
   );

   seg7_scan_driver #(.SCAN_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load(load), .hex_in(hex_in),
      .point_in(point_in), .blank_in(blank_in), .lz_en(lz_en),
      .ready(ready1), .hex_digit(hex_digit1), .le(le1), .dp(dp1),
      .anode_n(anode_n1), .digit_idx(digit_idx1)
   );

   // Reference model: elapsed cycles since reset determine the digit slot.
   int          divs [2] = '{4, 1};
   int          m_t [2];
   logic        m_pend [2];
   logic [15:0] m_sh_hex [2];
   logic [3:0]  m_sh_point [2];
   logic [3:0]  m_sh_blank [2];
   logic        m_sh_lz [2];
   logic [15:0] m_act_hex [2];
   logic [3:0]  m_act_point [2];
   logic [3:0]  m_act_blank [2];
   logic        m_act_lz [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_edge(input int k);
      logic old_pend;
      if (!rst_n) begin
         m_t[k] = 0;          m_pend[k] = 1'b0;
         m_sh_hex[k] = '0;    m_sh_point[k] = '0;  m_sh_blank[k] = '0; m_sh_lz[k] = 1'b0;
         m_act_hex[k] = '0;   m_act_point[k] = '0; m_act_blank[k] = 4'hF; m_act_lz[k] = 1'b0;
      end else begin
         old_pend = m_pend[k];
         if (((m_t[k] + 1) % (4 * divs[k]) == 0) && old_pend) begin
            m_act_hex[k] = m_sh_hex[k];     m_act_point[k] = m_sh_point[k];
            m_act_blank[k] = m_sh_blank[k]; m_act_lz[k] = m_sh_lz[k];
            m_pend[k] = 1'b0;
         end
         if (load && !old_pend) begin
            m_sh_hex[k] = hex_in;     m_sh_point[k] = point_in;
            m_sh_blank[k] = blank_in; m_sh_lz[k] = lz_en;
            m_pend[k] = 1'b1;
         end
         m_t[k]++;
      end
   endtask

   // Packed as {ready, digit_idx, anode_n, hex_digit, le, dp}.
   function automatic logic [12:0] expected(input int k);
      int         i;
      logic [3:0] nib;
      logic       lz, le_e, dp_e;
      logic [3:0] an;
      i    = (m_t[k] / divs[k]) % 4;
      nib  = 4'((m_act_hex[k] >> (4 * i)) & 16'hF);
      lz   = m_act_lz[k] && (i != 0) && ((m_act_hex[k] >> (4 * i)) == 16'h0);
      le_e = m_act_blank[k][i] | lz;
      dp_e = m_act_point[k][i] & ~le_e;
      an   = 4'hF & ~(4'(1) << i);
      return {~m_pend[k], 2'(i), an, nib, le_e, dp_e};
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      chk("dut4_outs", {19'd0, ready4, digit_idx4, anode_n4, hex_digit4, le4, dp4}, {19'd0, expected(0)});
      chk("dut1_outs", {19'd0, ready1, digit_idx1, anode_n1, hex_digit1, le1, dp1}, {19'd0, expected(1)});
   endtask

   task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b, input logic lz);
      load = 1'b1; hex_in = h; point_in = p; blank_in = b; lz_en = lz;
      cyc();
      load = 1'b0;
   endtask

   task automatic wait_idx4(input logic [1:0] target);
      for (int n = 0; n < 64; n++) begin
         if (digit_idx4 == target) return;
         cyc();
      end
      chk("wait_idx_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_ready4();
      for (int n = 0; n < 64; n++) begin
         if (ready4) return;
         cyc();
      end
      chk("wait_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset(input int len);
      rst_n = 1'b0;
      for (int n = 0; n < len; n++) cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; hex_in = '0; point_in = '0; blank_in = '0; lz_en = 1'b0;
      do_reset(3);
      chk("rst_anode", {28'd0, anode_n4}, 32'hE);
      chk("rst_le",    {31'd0, le4},      32'd1);
      chk("rst_dp",    {31'd0, dp4},      32'd0);
      chk("rst_ready", {31'd0, ready4},   32'd1);

      // Frame 12AB loaded mid-scan, then an overwrite attempt while pending.
      wait_idx4(2'd1);
      do_load(16'h12AB, 4'b0100, 4'b0000, 1'b0);
      chk("ld_ready_low", {31'd0, ready4}, 32'd0);
      do_load(16'hFFFF, 4'b1111, 4'b0000, 1'b0);
      wait_ready4();
      chk("swap_digit0", {28'd0, hex_digit4}, 32'hB);
      chk("swap_le",     {31'd0, le4},        32'd0);
      chk("swap_idx",    {30'd0, digit_idx4}, 32'd0);
      for (int n = 0; n < 12; n++) cyc();

      do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
      for (int n = 0; n < 24; n++) cyc();
      do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
      for (int n = 0; n < 24; n++) cyc();
      do_load(16'h8888, 4'b1001, 4'b1000, 1'b0);
      for (int n = 0; n < 24; n++) cyc();

      // Pending frame discarded by a reset before it can be shown.
      wait_idx4(2'd1);
      do_load(16'h1234, 4'b1111, 4'b0000, 1'b0);
      cyc();
      do_reset(1);
      chk("rst_drop_ready", {31'd0, ready4}, 32'd1);
      for (int n = 0; n < 24; n++) begin
         cyc();
         chk("rst_drop_dark", {31'd0, le4}, 32'd1);
      end

      for (int n = 0; n < 2000; n++) begin
         logic [15:0] h;
         h = 16'($urandom);
         for (int j = 0; j < 4; j++)
            if ($urandom_range(0, 1) == 0) h[4*j +: 4] = 4'h0;
         hex_in   = h;
         point_in = 4'($urandom);
         blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         lz_en    = 1'($urandom);
         load     = ($urandom_range(0, 2) == 0);
         rst_n    = ($urandom_range(0, 199) != 0);
         cyc();
      end
      rst_n = 1'b1; load = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed 4-digit driver for the team's MC14495-style hex-to-7-segment decoder.
- Takes a 16-bit hex frame with point and blank masks over a ready/load handshake.
- Scans one digit per slot, presenting {D3..D0}, LE and point to the decoder, with active-low anode selects to the display board.
- Frames swap only at a frame boundary, so the display never shows a torn value.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot; legal range >= 1; prescaler width = max(1, clog2(SCAN_DIV)).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
load  input  1  frame-load strobe; accepted only when ready=1
hex_in  input  16  frame value; [15:12]=digit3 (most significant) ... [3:0]=digit0
point_in  input  4  per-digit decimal point request, 1=lit
blank_in  input  4  per-digit blank request, 1=dark
lz_en  input  1  leading-zero suppression enable, captured with the frame
ready  output  1  1 = shadow slot free, load will be accepted
hex_digit  output  4  {D3,D2,D1,D0} to decoder for the current digit
le  output  1  decoder LE; 1 = digit dark
dp  output  1  decoder point input for the current digit
anode_n  output  4  active-low one-hot digit select
digit_idx  output  2  current digit index

Behaviour:
- State: prescaler, digit_idx, shadow frame {hex, point, blank, lz}, pending flag, active frame.
- All outputs are functions of registered state only. There is no combinational path from any input to any output.
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, digit_idx=0, pending=0.
  - active hex=0, point=0, blank=4'hF, lz=0; shadow cleared.
  - Resulting outputs: ready=1, anode_n=4'b1110, hex_digit=0, le=1, dp=0.
  - Reset mid-operation discards any pending frame.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler==SCAN_DIV-1).
  - SCAN_DIV=1 gives a tick every cycle.
- Scan: on tick, digit_idx <= digit_idx+1 mod 4, so each digit is held exactly SCAN_DIV cycles.
- Frame swap:
  - Occurs on a tick with digit_idx==3, i.e. the wrap to 0.
  - If pending=1 at that edge: active <= shadow and pending <= 0, in the same edge that digit_idx becomes 0.
  - Digit 0 of the new frame is therefore the first thing shown.
- Handshake:
  - ready = ~pending.
  - load=1 with ready=1: shadow <= {hex_in, point_in, blank_in, lz_en}, pending <= 1; ready falls the next cycle.
  - load=1 with ready=0: ignored entirely; the shadow is not overwritten.
  - load on the same edge as a wrap tick while pending=0: captured; the swap waits for the next wrap, since pending was 0 when sampled.
  - Worst-case load-to-display latency is 4*SCAN_DIV cycles.
- Per-digit decode for digit i = digit_idx, using the active frame:
  - hex_digit = active_hex[4i+3:4i].
  - lz_sup[i] = lz & (i!=0) & (all nibbles j>=i are 0). Digit 0 is never suppressed.
  - le = active_blank[i] | lz_sup[i].
  - dp = active_point[i] & ~le. A dark digit never shows its point.
  - anode_n = ~(4'b0001 << i).
- Simultaneous events: rst_n=0 wins over load and tick. A load arriving while pending=1 on a swap edge is ignored, because ready was 0 at that edge.

Test Plan:
- Reset with SCAN_DIV=4, rst_n low for 3 cycles:
  - Required after release: anode_n=1110, le=1, dp=0, ready=1.
  - anode_n holds for exactly 4 cycles, then becomes 1101 and continues 1011, 0111, 1110.
- Load hex=16'h12AB, point=4'b0100, blank=0, lz_en=0 while digit_idx=1:
  - ready=0 the next cycle; display stays dark through digits 2 and 3.
  - At the wrap: digit0 hex_digit=B, le=0, ready=1.
  - Digits then read A, 2 with dp=1, 1.
- While ready=0, load hex=16'hFFFF:
  - Ignored; the frame displayed after the next wrap is 12AB, not FFFF.
- lz_en=1, hex=16'h0050:
  - Digits 3 and 2 have le=1; digit1 shows 5 with le=0; digit0 shows 0 with le=0.
  - hex=16'h0000 with lz_en=1: only digit0 is lit, showing 0.
- blank=4'b1000, point=4'b1001, hex=16'h8888:
  - digit3 has le=1 and dp=0; digit0 has dp=1.
  - Repeat with SCAN_DIV=1: anode_n rotates every cycle.
- Load accepted, then rst_n pulsed low before the wrap:
  - ready=1 and le=1 on all digits afterwards.
  - The pending frame is never displayed.
